alu_arbiter: RTL and testbench

Shares the single `arithmetic_logic_unit` instance between two requesters: port 0 is the execute stage and port 1 is the fetch/branch unit (PC+4, PC+offset). The block performs round-robin arbitration, registers the winning operands and drives the ALU for one cycle. It then captures the result and condition codes, keeps the architectural NZCV flag register, and returns a response through a valid/ready handshake. The ALU carry-in always comes from the stored C flag.

---
 rtl/alu_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one ALU between the execute stage (port 0)
// and the fetch/branch unit (port 1), and owns the NZCV flag register.
module alu_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic [4:0]  req0_op,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req0_s,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [4:0]  req1_op,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic        req1_s,
   output logic        req1_ready,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [4:0]  alu_op,
   output logic        alu_cin,
   input  logic [31:0] alu_out,
   input  logic        alu_z,
   input  logic        alu_n,
   input  logic        alu_c,
   input  logic        alu_v,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_data,
   output logic        rsp_wr,
   output logic        rsp_err,
   output logic [3:0]  flags
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state_reg, state_next;
   logic        last_grant_reg;
   logic [4:0]  issue_op_reg;
   logic [31:0] issue_a_reg, issue_b_reg;
   logic        issue_s_reg, issue_id_reg;
   logic [3:0]  flags_reg, flags_next;
   logic [31:0] rsp_data_reg, rsp_data_next;
   logic        rsp_wr_reg, rsp_wr_next;
   logic        rsp_err_reg, rsp_err_next;
   logic        rsp_id_reg;

   logic        grant_any, grant_id, exec_active;
   logic        upd_nzc, upd_v;

   // Port 1 wins a single request on its own; a tie goes to whoever lost last.
   always_comb begin
      grant_any  = (state_reg == IDLE) && !reset && (req0_valid || req1_valid);
      grant_id   = (req0_valid && req1_valid) ? ~last_grant_reg : req1_valid;
      req0_ready = grant_any && !grant_id;
      req1_ready = grant_any && grant_id;
   end

   always_comb begin
      exec_active = (state_reg == EXEC) && !reset;
      alu_a       = exec_active ? issue_a_reg  : 32'd0;
      alu_b       = exec_active ? issue_b_reg  : 32'd0;
      alu_op      = exec_active ? issue_op_reg : 5'd0;
      alu_cin     = exec_active && flags_reg[1];
   end

   // Opcode class decides write-back, error and which flag groups move.
   always_comb begin
      upd_nzc      = 1'b0;
      upd_v        = 1'b0;
      rsp_wr_next  = 1'b0;
      rsp_err_next = 1'b0;
      if (issue_op_reg[4:1] == 4'b0000 || issue_op_reg[4:2] == 3'b011) begin
         rsp_wr_next = 1'b1;
         upd_nzc     = issue_s_reg;
      end else if (issue_op_reg[4:3] == 2'b00) begin
         rsp_wr_next = 1'b1;
         upd_nzc     = issue_s_reg;
         upd_v       = issue_s_reg;
      end else if (issue_op_reg[4:2] == 3'b010) begin
         upd_nzc = 1'b1;
         upd_v   = issue_op_reg[1];
      end else if (issue_op_reg[4:2] == 3'b100) begin
         rsp_wr_next = 1'b1;
      end else begin
         rsp_err_next = 1'b1;
      end
      rsp_data_next = rsp_wr_next ? alu_out : 32'd0;
      flags_next    = {upd_nzc ? alu_n : flags_reg[3],
                       upd_nzc ? alu_z : flags_reg[2],
                       upd_nzc ? alu_c : flags_reg[1],
                       upd_v   ? alu_v : flags_reg[0]};
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (grant_any) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         last_grant_reg <= 1'b1;
         issue_op_reg   <= 5'd0;
         issue_a_reg    <= 32'd0;
         issue_b_reg    <= 32'd0;
         issue_s_reg    <= 1'b0;
         issue_id_reg   <= 1'b0;
         flags_reg      <= 4'd0;
         rsp_data_reg   <= 32'd0;
         rsp_wr_reg     <= 1'b0;
         rsp_err_reg    <= 1'b0;
         rsp_id_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (grant_any) begin
            last_grant_reg <= grant_id;
            issue_id_reg   <= grant_id;
            issue_op_reg   <= grant_id ? req1_op : req0_op;
            issue_a_reg    <= grant_id ? req1_a  : req0_a;
            issue_b_reg    <= grant_id ? req1_b  : req0_b;
            issue_s_reg    <= grant_id ? req1_s  : req0_s;
         end
         if (state_reg == EXEC) begin
            flags_reg    <= flags_next;
            rsp_data_reg <= rsp_data_next;
            rsp_wr_reg   <= rsp_wr_next;
            rsp_err_reg  <= rsp_err_next;
            rsp_id_reg   <= issue_id_reg;
         end
      end
   end

   assign rsp_valid = (state_reg == RESP);
   assign rsp_id    = rsp_id_reg;
   assign rsp_data  = rsp_data_reg;
   assign rsp_wr    = rsp_wr_reg;
   assign rsp_err   = rsp_err_reg;
   assign flags     = flags_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a small ALU model sits on the ALU port, a
// negedge monitor predicts grants, responses and flags from the opcode rules.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [4:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        req0_s, req1_s;
   logic [31:0] alu_a, alu_b, alu_out;
   logic [4:0]  alu_op;
   logic        alu_cin, alu_z, alu_n, alu_c, alu_v;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_wr, rsp_err;
   logic [31:0] rsp_data;
   logic [3:0]  flags;

   always #5 clk = ~clk;

   alu_arbiter dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req0_s(req0_s), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .req1_s(req1_s), .req1_ready(req1_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
      .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_wr(rsp_wr), .rsp_err(rsp_err), .flags(flags)
   );

   typedef struct packed {
      logic [31:0] out;
      logic        n, z, c, v;
   } alu_res_t;

   // Stand-in ALU: logical ops report C = a[31], V = a[30] so kept flags are observable.
   function automatic alu_res_t alu_fn(input logic [4:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic cin);
      alu_res_t    r;
      logic [31:0] x, y;
      logic        ci, ar;
      logic [32:0] w;
      x = a; y = b; ci = 1'b0; ar = 1'b1;
      r.out = 32'd0;
      case (op)
         5'd2, 5'd10, 5'd19: begin y = ~b; ci = 1'b1; end
         5'd3:               begin x = b; y = ~a; ci = 1'b1; end
         5'd4, 5'd11, 5'd16: ci = 1'b0;
         5'd5:               ci = cin;
         5'd6:               begin y = ~b; ci = cin; end
         5'd7:               begin x = b; y = ~a; ci = cin; end
         5'd17:              y = 32'd4;
         default:            ar = 1'b0;
      endcase
      w = {1'b0, x} + {1'b0, y} + {32'd0, ci};
      if (ar) begin
         r.out = w[31:0];
         r.c   = w[32];
         r.v   = (x[31] == y[31]) && (r.out[31] != x[31]);
      end else begin
         case (op)
            5'd0, 5'd8:  r.out = a & b;
            5'd1, 5'd9:  r.out = a ^ b;
            5'd12:       r.out = a | b;
            5'd13:       r.out = b;
            5'd14:       r.out = a & ~b;
            5'd15:       r.out = ~b;
            5'd18:       r.out = a;
            default:     r.out = a ^ ~b;
         endcase
         r.c = a[31];
         r.v = a[30];
      end
      r.n = r.out[31];
      r.z = (r.out == 32'd0);
      return r;
   endfunction

   alu_res_t env_res;
   always_comb env_res = alu_fn(alu_op, alu_a, alu_b, alu_cin);
   assign alu_out = env_res.out;
   assign alu_n   = env_res.n;
   assign alu_z   = env_res.z;
   assign alu_c   = env_res.c;
   assign alu_v   = env_res.v;

   typedef struct {
      int          due;
      logic        id;
      logic [31:0] data;
      logic        wr;
      logic        err;
      logic [3:0]  flg;
   } exp_t;

   // Expected outcome of one operation from the opcode-class rules, given the flags before it.
   function automatic exp_t model_op(input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic s, input logic [3:0] f);
      exp_t     e;
      alu_res_t r;
      r = alu_fn(op, a, b, f[1]);
      e.due = 0; e.id = 1'b0; e.data = 32'd0; e.wr = 1'b0; e.err = 1'b0; e.flg = f;
      if (op <= 5'd1 || (op >= 5'd12 && op <= 5'd15)) begin
         e.wr = 1'b1; e.data = r.out;
         if (s) e.flg[3:1] = {r.n, r.z, r.c};
      end else if (op >= 5'd2 && op <= 5'd7) begin
         e.wr = 1'b1; e.data = r.out;
         if (s) e.flg = {r.n, r.z, r.c, r.v};
      end else if (op >= 5'd8 && op <= 5'd11) begin
         e.flg[3:1] = {r.n, r.z, r.c};
         if (op >= 5'd10) e.flg[0] = r.v;
      end else if (op >= 5'd16 && op <= 5'd19) begin
         e.wr = 1'b1; e.data = r.out;
      end else begin
         e.err = 1'b1;
      end
      return e;
   endfunction

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   exp_t sbq[$];
   exp_t ent;
   logic [3:0] m_flags = 4'd0, vis_flags = 4'd0;
   logic m_last = 1'b1, m_idle = 1'b1;
   logic e0, e1, gid;
   bit   rsp_due;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: checks this cycle's outputs, then applies what the coming edge will do.
   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         check("ready_in_reset", 32'({req0_ready, req1_ready}), 32'd0);
         sbq.delete();
         m_flags = 4'd0; vis_flags = 4'd0; m_last = 1'b1; m_idle = 1'b1;
      end else begin
         rsp_due = (sbq.size() > 0) && (cyc >= sbq[0].due);
         if (rsp_due) vis_flags = sbq[0].flg;
         check("flags", 32'(flags), 32'(vis_flags));
         check("rsp_valid", 32'(rsp_valid), 32'(rsp_due));
         if (rsp_due && rsp_valid) begin
            check("rsp_id", 32'(rsp_id), 32'(sbq[0].id));
            check("rsp_data", rsp_data, sbq[0].data);
            check("rsp_wr", 32'(rsp_wr), 32'(sbq[0].wr));
            check("rsp_err", 32'(rsp_err), 32'(sbq[0].err));
         end
         e0 = 1'b0; e1 = 1'b0; gid = 1'b0;
         if (m_idle && (req0_valid || req1_valid)) begin
            gid = (req0_valid && req1_valid) ? ~m_last : req1_valid;
            e0 = !gid; e1 = gid;
         end
         check("ready", 32'({req0_ready, req1_ready}), 32'({e0, e1}));
         if (rsp_due && rsp_ready) begin
            $display("rsp id=%0d data=%08h wr=%0d err=%0d flags=%04b",
                     sbq[0].id, sbq[0].data, sbq[0].wr, sbq[0].err, sbq[0].flg);
            void'(sbq.pop_front());
            m_idle = 1'b1;
         end
         if (e0 || e1) begin
            ent = gid ? model_op(req1_op, req1_a, req1_b, req1_s, m_flags)
                      : model_op(req0_op, req0_a, req0_b, req0_s, m_flags);
            ent.id  = gid;
            ent.due = cyc + 2;
            sbq.push_back(ent);
            m_flags = ent.flg;
            m_last  = gid;
            m_idle  = 1'b0;
         end
      end
   end

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic p, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic s);
      bit got;
      got = 0;
      if (p) begin req1_op = op; req1_a = a; req1_b = b; req1_s = s; req1_valid = 1'b1; end
      else   begin req0_op = op; req0_a = a; req0_b = b; req0_s = s; req0_valid = 1'b1; end
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (p ? req1_ready : req0_ready) got = 1;
      end
      if (!got) begin
         checks++; failures++;
         $display("FAIL grant_timeout actual=no_grant required=grant port=%0d", p);
      end
      @(posedge clk); #1;
      if (p) req1_valid = 1'b0; else req0_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; rsp_ready = 1'b1;
      req0_valid = 1'b0; req0_op = 5'd0; req0_a = 32'd0; req0_b = 32'd0; req0_s = 1'b0;
      req1_valid = 1'b0; req1_op = 5'd0; req1_a = 32'd0; req1_b = 32'd0; req1_s = 1'b0;
      idle_cycles(3);
      reset = 1'b0;
      idle_cycles(2);

      send(1'b0, 5'd4, 32'd5, 32'd7, 1'b1);
      idle_cycles(4);

      req0_op = 5'd13; req0_a = $urandom; req0_b = 32'd0; req0_s = 1'b1; req0_valid = 1'b1;
      req1_op = 5'd13; req1_a = $urandom; req1_b = 32'd1; req1_s = 1'b0; req1_valid = 1'b1;
      idle_cycles(13);
      req0_valid = 1'b0; req1_valid = 1'b0;
      idle_cycles(4);

      send(1'b0, 5'd4, 32'hFFFF_FFFF, 32'd1, 1'b1);
      idle_cycles(3);
      send(1'b0, 5'd5, 32'd0, 32'd0, 1'b0);
      idle_cycles(3);
      send(1'b1, 5'd10, 32'd3, 32'd3, 1'b0);
      idle_cycles(3);
      send(1'b1, 5'd17, 32'h100, 32'd9, 1'b1);
      idle_cycles(3);
      send(1'b0, 5'd22, 32'd1, 32'd2, 1'b1);
      idle_cycles(3);

      rsp_ready = 1'b0;
      send(1'b0, 5'd2, 32'd9, 32'd4, 1'b1);
      req1_op = 5'd4; req1_a = 32'd20; req1_b = 32'd22; req1_s = 1'b1; req1_valid = 1'b1;
      idle_cycles(7);
      rsp_ready = 1'b1;
      send(1'b1, 5'd4, 32'd20, 32'd22, 1'b1);
      idle_cycles(3);

      send(1'b1, 5'd10, 32'd1, 32'd2, 1'b1);
      reset = 1'b1;
      idle_cycles(1);
      reset = 1'b0;
      req0_op = 5'd4; req0_a = 32'd1; req0_b = 32'd1; req0_s = 1'b0; req0_valid = 1'b1;
      req1_op = 5'd4; req1_a = 32'd2; req1_b = 32'd2; req1_s = 1'b0; req1_valid = 1'b1;
      idle_cycles(1);
      req0_valid = 1'b0; req1_valid = 1'b0;
      idle_cycles(4);

      repeat (400) begin
         req0_valid = ($urandom_range(0, 2) != 0);
         req1_valid = ($urandom_range(0, 2) != 0);
         req0_op = 5'($urandom_range(0, 31)); req1_op = 5'($urandom_range(0, 31));
         req0_a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
         req1_a = $urandom;
         req0_b = $urandom; req1_b = ($urandom_range(0, 7) == 0) ? 32'd1 : $urandom;
         req0_s = 1'($urandom_range(0, 1)); req1_s = 1'($urandom_range(0, 1));
         rsp_ready = ($urandom_range(0, 3) != 0);
         idle_cycles(1);
      end
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      idle_cycles(10);
      check("queue_drained", 32'(sbq.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
